// File: rtl/lt_fallback_seq.sv
// -----------------------------------------------------------------------------
// lt_fallback_seq
//   Link-training sequencer sitting above the clock-recovery / channel-EQ pair.
//   It latches the requested rate and lane count, launches clock recovery and
//   watches each attempt for pass, fail or watchdog timeout. Failed attempts are
//   retried RETRY_MAX times. After that the sequencer falls back through the
//   rate/lane ladder. A final pass or fail level is reported to the LPM.
//
//   Optional build macro: LT_LANE_FIRST_EN
//     undefined : fallback steps the rate down first (1E->14->0A->06). At
//                 MIN_BW it halves the lanes and restores the requested rate.
//     defined   : fallback halves the lanes first (11->01->00). At one lane it
//                 steps the rate down once and restores the requested lanes.
//
// Ports
//   clk, rst_n                  100 kHz clock, asynchronous active-low reset
//   lt_start / lt_abort         one-cycle request pulses from the LPM
//   req_bw[7:0] / req_lc[1:0]   requested rate code / lane code
//   cr_completed, fsm_cr_failed CR phase result
//   eq_lt_pass, eq_lt_failed,
//   eq_fsm_cr_failed            EQ phase result
//   cr_start                    one-cycle pulse launching an attempt
//   cur_bw / cur_lc             configuration of the current attempt
//   lt_busy, lt_pass, lt_fail   training status levels
//   retry_cnt / fallback_cnt    attempts at this config / fallbacks taken
// -----------------------------------------------------------------------------
module lt_fallback_seq #(
  parameter int unsigned RETRY_MAX   = 2,
  parameter int unsigned TIMEOUT_CYC = 4000,
  parameter logic [7:0]  MIN_BW      = 8'h06
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lt_start,
  input  logic       lt_abort,
  input  logic [7:0] req_bw,
  input  logic [1:0] req_lc,
  input  logic       cr_completed,
  input  logic       fsm_cr_failed,
  input  logic       eq_lt_pass,
  input  logic       eq_lt_failed,
  input  logic       eq_fsm_cr_failed,
  output logic       cr_start,
  output logic [7:0] cur_bw,
  output logic [1:0] cur_lc,
  output logic       lt_busy,
  output logic       lt_pass,
  output logic       lt_fail,
  output logic [2:0] retry_cnt,
  output logic [3:0] fallback_cnt
);

  localparam int unsigned        WD_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]    WD_LAST     = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]         RETRY_MAX_L = 3'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CR_RUN, S_EQ_RUN, S_EVAL, S_PASS, S_FAIL
  } state_e;

  function automatic logic bw_is_code(input logic [7:0] bw);
    return (bw == 8'h06) || (bw == 8'h0A) || (bw == 8'h14) || (bw == 8'h1E);
  endfunction

  // Next rung down the rate ladder. 00 means there is no lower rate.
  function automatic logic [7:0] bw_lower(input logic [7:0] bw);
    case (bw)
      8'h1E:   return 8'h14;
      8'h14:   return 8'h0A;
      8'h0A:   return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [1:0] lc_half(input logic [1:0] lc);
    return (lc == 2'b11) ? 2'b01 : 2'b00;
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      cur_bw_q, cur_bw_d, req_bw_q, req_bw_d;
  logic [1:0]      cur_lc_q, cur_lc_d, req_lc_q, req_lc_d;
  logic [2:0]      retry_q, retry_d;
  logic [3:0]      fb_cnt_q, fb_cnt_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            cr_start_q, cr_start_d;
  logic            busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;

  logic            req_ok;
  logic [7:0]      bw_dn;
  logic            bw_can_step;
  logic            fb_ok;
  logic [7:0]      fb_bw;
  logic [1:0]      fb_lc;

  assign req_ok      = (req_lc != 2'b10) && bw_is_code(req_bw) && (req_bw >= MIN_BW);
  assign bw_dn       = bw_lower(cur_bw_q);
  // Step down only to a real rung that is still at or above the floor.
  assign bw_can_step = (cur_bw_q > MIN_BW) && (bw_dn != 8'h00) && (bw_dn >= MIN_BW);

  // Fallback target, computed from the current attempt's configuration.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    fb_ok = 1'b0;
    fb_bw = cur_bw_q;
    fb_lc = cur_lc_q;
`ifdef LT_LANE_FIRST_EN
    if (cur_lc_q != 2'b00) begin
      fb_ok = 1'b1;
      fb_lc = lc_half(cur_lc_q);
    end else if (bw_can_step) begin
      fb_ok = 1'b1;
      fb_bw = bw_dn;
      fb_lc = req_lc_q;
    end
`else
    if (bw_can_step) begin
      fb_ok = 1'b1;
      fb_bw = bw_dn;
    end else if (cur_lc_q != 2'b00) begin
      fb_ok = 1'b1;
      fb_lc = lc_half(cur_lc_q);
      fb_bw = req_bw_q;
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cur_bw_d   = cur_bw_q;
    cur_lc_d   = cur_lc_q;
    req_bw_d   = req_bw_q;
    req_lc_d   = req_lc_q;
    retry_d    = retry_q;
    fb_cnt_d   = fb_cnt_q;
    wdog_d     = wdog_q;
    cr_start_d = 1'b0;

    if (lt_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_PASS, S_FAIL: begin
          if (lt_start) begin
            state_d  = S_LOAD;
            retry_d  = 3'd0;
            fb_cnt_d = 4'd0;
          end
        end
        S_LOAD: begin
          if (req_ok) begin
            cur_bw_d   = req_bw;
            cur_lc_d   = req_lc;
            req_bw_d   = req_bw;
            req_lc_d   = req_lc;
            state_d    = S_CR_RUN;
            cr_start_d = 1'b1;
            wdog_d     = '0;
          end else begin
            state_d = S_FAIL;
          end
        end
        S_CR_RUN: begin
          // A failure outranks a simultaneous completion.
          if (fsm_cr_failed) begin
            state_d = S_EVAL;
          end else if (cr_completed) begin
            state_d = S_EQ_RUN;
            wdog_d  = '0;
          end else if (wdog_q == WD_LAST) begin
            state_d = S_EVAL;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        S_EQ_RUN: begin
          if (eq_lt_failed || eq_fsm_cr_failed) begin
            state_d = S_EVAL;
          end else if (eq_lt_pass) begin
            state_d = S_PASS;
          end else if (wdog_q == WD_LAST) begin
            state_d = S_EVAL;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        S_EVAL: begin
          if (retry_q < RETRY_MAX_L) begin
            retry_d    = retry_q + 3'd1;
            state_d    = S_CR_RUN;
            cr_start_d = 1'b1;
            wdog_d     = '0;
          end else if (fb_ok) begin
            retry_d    = 3'd0;
            fb_cnt_d   = (fb_cnt_q == 4'hF) ? 4'hF : fb_cnt_q + 4'd1;
            cur_bw_d   = fb_bw;
            cur_lc_d   = fb_lc;
            state_d    = S_CR_RUN;
            cr_start_d = 1'b1;
            wdog_d     = '0;
          end else begin
            state_d = S_FAIL;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Status levels follow the state being entered, so they are registered.
    busy_d = (state_d == S_LOAD) || (state_d == S_CR_RUN) ||
             (state_d == S_EQ_RUN) || (state_d == S_EVAL);
    pass_d = (state_d == S_PASS);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_bw_q   <= 8'h00;
      cur_lc_q   <= 2'b00;
      req_bw_q   <= 8'h00;
      req_lc_q   <= 2'b00;
      retry_q    <= 3'd0;
      fb_cnt_q   <= 4'd0;
      wdog_q     <= '0;
      cr_start_q <= 1'b0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q    <= state_d;
      cur_bw_q   <= cur_bw_d;
      cur_lc_q   <= cur_lc_d;
      req_bw_q   <= req_bw_d;
      req_lc_q   <= req_lc_d;
      retry_q    <= retry_d;
      fb_cnt_q   <= fb_cnt_d;
      wdog_q     <= wdog_d;
      cr_start_q <= cr_start_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  assign cr_start     = cr_start_q;
  assign cur_bw       = cur_bw_q;
  assign cur_lc       = cur_lc_q;
  assign lt_busy      = busy_q;
  assign lt_pass      = pass_q;
  assign lt_fail      = fail_q;
  assign retry_cnt    = retry_q;
  assign fallback_cnt = fb_cnt_q;

endmodule

// File: tb/tb_lt_fallback_seq.sv
// -----------------------------------------------------------------------------
// tb_lt_fallback_seq
//   Directed bench for lt_fallback_seq (RETRY_MAX=2, TIMEOUT_CYC=100,
//   MIN_BW=06). Inputs are driven and outputs sampled on the falling edge. A
//   monitor logs the configuration present at every cr_start pulse. Expected
//   fallback order follows LT_LANE_FIRST_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_lt_fallback_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lt_start, lt_abort;
  logic [7:0] req_bw;
  logic [1:0] req_lc;
  logic       cr_completed, fsm_cr_failed;
  logic       eq_lt_pass, eq_lt_failed, eq_fsm_cr_failed;
  logic       cr_start;
  logic [7:0] cur_bw;
  logic [1:0] cur_lc;
  logic       lt_busy, lt_pass, lt_fail;
  logic [2:0] retry_cnt;
  logic [3:0] fallback_cnt;

  int checks   = 0;
  int failures = 0;

  lt_fallback_seq #(
    .RETRY_MAX   (2),
    .TIMEOUT_CYC (100),
    .MIN_BW      (8'h06)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lt_start         (lt_start),
    .lt_abort         (lt_abort),
    .req_bw           (req_bw),
    .req_lc           (req_lc),
    .cr_completed     (cr_completed),
    .fsm_cr_failed    (fsm_cr_failed),
    .eq_lt_pass       (eq_lt_pass),
    .eq_lt_failed     (eq_lt_failed),
    .eq_fsm_cr_failed (eq_fsm_cr_failed),
    .cr_start         (cr_start),
    .cur_bw           (cur_bw),
    .cur_lc           (cur_lc),
    .lt_busy          (lt_busy),
    .lt_pass          (lt_pass),
    .lt_fail          (lt_fail),
    .retry_cnt        (retry_cnt),
    .fallback_cnt     (fallback_cnt)
  );

  always #5 clk = ~clk;

  // Log of configurations seen at each cr_start pulse.
  int         cr_count = 0;
  logic [7:0] log_bw [0:63];
  logic [1:0] log_lc [0:63];

  always @(posedge clk) begin
    if (rst_n && cr_start) begin
      if (cr_count < 64) begin
        log_bw[cr_count] = cur_bw;
        log_lc[cr_count] = cur_lc;
      end
      cr_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=no_finish required=finish");
    $fatal(1, "bench time limit expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    lt_start = 1'b1;
    tick();
    lt_start = 1'b0;
  endtask

  task automatic wait_cr(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cr_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_fail(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (lt_fail === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  logic [7:0] exp_bw [0:5];
  logic [1:0] exp_lc [0:5];

  initial begin
    bit ok;
    int base;
    int n;
    bit cfg_ok;

`ifdef LT_LANE_FIRST_EN
    exp_bw[0] = 8'h14; exp_lc[0] = 2'b01;
    exp_bw[1] = 8'h14; exp_lc[1] = 2'b00;
    exp_bw[2] = 8'h0A; exp_lc[2] = 2'b01;
    exp_bw[3] = 8'h0A; exp_lc[3] = 2'b00;
    exp_bw[4] = 8'h06; exp_lc[4] = 2'b01;
    exp_bw[5] = 8'h06; exp_lc[5] = 2'b00;
`else
    exp_bw[0] = 8'h14; exp_lc[0] = 2'b01;
    exp_bw[1] = 8'h0A; exp_lc[1] = 2'b01;
    exp_bw[2] = 8'h06; exp_lc[2] = 2'b01;
    exp_bw[3] = 8'h14; exp_lc[3] = 2'b00;
    exp_bw[4] = 8'h0A; exp_lc[4] = 2'b00;
    exp_bw[5] = 8'h06; exp_lc[5] = 2'b00;
`endif

    // ---- reset ----
    rst_n = 1'b0; lt_start = 1'b0; lt_abort = 1'b0;
    req_bw = 8'h00; req_lc = 2'b00;
    cr_completed = 1'b0; fsm_cr_failed = 1'b0;
    eq_lt_pass = 1'b0; eq_lt_failed = 1'b0; eq_fsm_cr_failed = 1'b0;
    repeat (3) tick();
    check("rst_busy",     lt_busy,      0);
    check("rst_pass",     lt_pass,      0);
    check("rst_fail",     lt_fail,      0);
    check("rst_cr_start", cr_start,     0);
    check("rst_cur_bw",   cur_bw,       8'h00);
    check("rst_cur_lc",   cur_lc,       2'b00);
    check("rst_retry",    retry_cnt,    0);
    check("rst_fallback", fallback_cnt, 0);
    rst_n = 1'b1;
    tick();

    // ---- happy path: 1E / 4 lanes ----
    req_bw = 8'h1E; req_lc = 2'b11;
    base = cr_count;
    pulse_start();
    check("hp_busy_load", lt_busy, 1);
    wait_cr(5, ok);
    check("hp_cr_start_seen", ok, 1);
    repeat (10) tick();
    cr_completed = 1'b1; tick(); cr_completed = 1'b0;
    repeat (19) tick();
    eq_lt_pass = 1'b1;
    check("hp_pass_before", lt_pass, 0);
    tick();
    eq_lt_pass = 1'b0;
    check("hp_pass",       lt_pass,           1);
    check("hp_busy_done",  lt_busy,           0);
    check("hp_cr_pulses",  cr_count - base,   1);
    check("hp_cur_bw",     cur_bw,            8'h1E);
    check("hp_cur_lc",     cur_lc,            2'b11);
    check("hp_fallback",   fallback_cnt,      0);

    // ---- exhaustive fallback: 14 / 2 lanes, CR fails every attempt ----
    req_bw = 8'h14; req_lc = 2'b01;
    base = cr_count;
    pulse_start();
    check("ex_pass_cleared", lt_pass, 0);
    for (int k = 0; k < 18; k++) begin
      wait_cr(6, ok);
      check($sformatf("ex_cr_start_%0d", k), ok, 1);
      fsm_cr_failed = 1'b1; tick(); fsm_cr_failed = 1'b0;
    end
    wait_fail(6, ok);
    check("ex_fail_seen",  ok,              1);
    check("ex_fail",       lt_fail,         1);
    check("ex_cr_pulses",  cr_count - base, 18);
    check("ex_fallback",   fallback_cnt,    5);
    check("ex_busy",       lt_busy,         0);
    for (int c = 0; c < 6; c++) begin
      cfg_ok = 1'b1;
      for (int r = 0; r < 3; r++) begin
        if (log_bw[base + 3*c + r] !== exp_bw[c] || log_lc[base + 3*c + r] !== exp_lc[c])
          cfg_ok = 1'b0;
      end
      check($sformatf("ex_config_%0d_bw%0h_lc%0h", c, exp_bw[c], exp_lc[c]), cfg_ok, 1);
    end

    // ---- timeout: 0A / 1 lane, no phase response ----
    req_bw = 8'h0A; req_lc = 2'b00;
    pulse_start();
    check("to_fail_cleared", lt_fail, 0);
    wait_cr(5, ok);
    check("to_cr_start_seen", ok, 1);
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (cr_start) break;
    end
    check("to_interval", n,         101);
    check("to_retry",    retry_cnt, 1);
    check("to_cur_bw",   cur_bw,    8'h0A);

    // ---- priority: CR fail and complete together -> EVAL, retry ----
    cr_completed = 1'b1; fsm_cr_failed = 1'b1;
    tick();
    cr_completed = 1'b0; fsm_cr_failed = 1'b0;
    check("pr_cr_eval_no_start", cr_start, 0);
    tick();
    check("pr_cr_retry_start", cr_start,  1);
    check("pr_cr_retry_cnt",   retry_cnt, 2);

    // ---- priority: EQ pass and fail together -> fallback to 06 / 1 lane ----
    cr_completed = 1'b1; tick(); cr_completed = 1'b0;
    eq_lt_pass = 1'b1; eq_lt_failed = 1'b1;
    tick();
    eq_lt_pass = 1'b0; eq_lt_failed = 1'b0;
    check("pr_eq_pass_low", lt_pass, 0);
    tick();
    check("pr_eq_start",    cr_start,     1);
    check("pr_eq_retry",    retry_cnt,    0);
    check("pr_eq_fallback", fallback_cnt, 1);
    check("pr_eq_cur_bw",   cur_bw,       8'h06);
    check("pr_eq_pass_end", lt_pass,      0);

    // ---- abort mid EQ_RUN, with a simultaneous start ----
    cr_completed = 1'b1; tick(); cr_completed = 1'b0;
    repeat (3) tick();
    check("ab_busy_before", lt_busy, 1);
    lt_abort = 1'b1; lt_start = 1'b1;
    tick();
    lt_abort = 1'b0; lt_start = 1'b0;
    check("ab_busy",     lt_busy,      0);
    check("ab_pass",     lt_pass,      0);
    check("ab_fail",     lt_fail,      0);
    check("ab_cr_start", cr_start,     0);
    check("ab_cur_bw",   cur_bw,       8'h06);
    check("ab_fallback", fallback_cnt, 1);
    tick();
    eq_lt_pass = 1'b1; tick(); eq_lt_pass = 1'b0;
    tick();
    check("ab_late_pass_ignored", lt_pass, 0);
    check("ab_still_idle",        lt_busy, 0);

    // ---- invalid requests ----
    base = cr_count;
    req_bw = 8'h14; req_lc = 2'b10;
    pulse_start();
    check("inv_lc_not_yet", lt_fail, 0);
    tick();
    check("inv_lc_fail", lt_fail, 1);
    check("inv_lc_busy", lt_busy, 0);
    req_bw = 8'h0C; req_lc = 2'b00;
    pulse_start();
    check("inv_bw_cleared", lt_fail, 0);
    tick();
    check("inv_bw_fail",      lt_fail,         1);
    check("inv_no_cr_start",  cr_count - base, 0);

    // ---- reset mid-training ----
    req_bw = 8'h1E; req_lc = 2'b01;
    pulse_start();
    wait_cr(5, ok);
    check("rm_cr_start_seen", ok, 1);
    rst_n = 1'b0;
    #1;
    check("rm_busy",   lt_busy, 0);
    check("rm_cur_bw", cur_bw,  8'h00);
    check("rm_cr",     cr_start, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
